// File: rtl/layer_line_reader_pkg.sv
// layer_line_reader shared constants and FSM state type.
// Optional build macro: LAYER_LINE_READER_HSCALE_EN (see hscale_accum).
package layer_line_reader_pkg;

  localparam int LINEBUF_DEPTH = 768;
  localparam int HSCALE_UNITY  = 128;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } state_e;

endpackage

// File: rtl/layer_line_reader_hscale.sv
// hscale_accum: source-index accumulator for the line reader.
// LAYER_LINE_READER_HSCALE_EN selects fractional stepping; otherwise +1.
module hscale_accum
  import layer_line_reader_pkg::*;
#(
  parameter int FRAC_BITS = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] scale,
  output logic [9:0] idx
);

`ifdef LAYER_LINE_READER_HSCALE_EN
  localparam int AW = FRAC_BITS + 10;

  logic [AW-1:0] acc_q, acc_d, base;
  logic [7:0]    scale_q, scale_d;

  // A load restarts from 0 in the same cycle, so a coincident step uses 0.
  always_comb begin
    scale_d = load ? scale : scale_q;
    base    = load ? '0 : acc_q;
    acc_d   = base;
    if (load || step) begin
      acc_d = step ? base + AW'(scale_d) : base;
    end
  end

  assign idx = base[AW-1:FRAC_BITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      scale_q <= 8'(HSCALE_UNITY);
    end else begin
      acc_q   <= acc_d;
      scale_q <= scale_d;
    end
  end
`else
  localparam int unused_frac_bits = FRAC_BITS;

  logic [9:0] acc_q, acc_d, base;
  logic       unused_scale;

  assign unused_scale = ^scale;

  always_comb begin
    base  = load ? '0 : acc_q;
    acc_d = base + 10'(step);
  end

  assign idx = base;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

endmodule

// File: rtl/layer_line_reader.sv
// layer_line_reader: composer-side line-buffer reader with h-scaling.
// Build macro: LAYER_LINE_READER_HSCALE_EN enables fractional hscale.
module layer_line_reader
  import layer_line_reader_pkg::*;
#(
  parameter int ACTIVE_WIDTH = 640,
  parameter int FRAC_BITS    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_start,
  input  logic       next_pixel,
  input  logic [7:0] hscale,
  output logic [9:0] composer_rd_idx,
  input  logic [7:0] composer_rd_data,
  output logic [7:0] pixel_data,
  output logic       pixel_valid,
  output logic       line_done,
  output logic       busy
);

  localparam logic [9:0] WIDTH_L = 10'(ACTIVE_WIDTH);
  localparam logic [9:0] DEPTH_L = 10'(LINEBUF_DEPTH);

  state_e     state_q, state_d;
  logic [9:0] cnt_q, cnt_d, cnt_base, cnt_inc;
  logic       req_v_q, req_v_d;
  logic       req_oor_q, req_oor_d;
  logic [7:0] pix_q, pix_d;
  logic       pv_q, pv_d;
  logic       done_q, done_d;
  logic       fetch;

  hscale_accum #(
    .FRAC_BITS(FRAC_BITS)
  ) u_accum (
    .clk  (clk),
    .rst  (rst),
    .load (line_start),
    .step (fetch),
    .scale(hscale),
    .idx  (composer_rd_idx)
  );

  always_comb begin
    fetch    = next_pixel & (line_start | (state_q == ACTIVE));
    cnt_base = line_start ? '0 : cnt_q;
    cnt_inc  = cnt_base + 10'(fetch);
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;

    if (line_start) begin
      state_d = ACTIVE;
      cnt_d   = cnt_inc;
    end else begin
      unique case (state_q)
        ACTIVE: cnt_d = cnt_inc;
        DRAIN: begin
          // Last request has reached the output register.
          if (!req_v_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end

    if (fetch && cnt_inc == WIDTH_L) begin
      state_d = DRAIN;
    end
  end

  always_comb begin
    req_v_d   = fetch;
    req_oor_d = composer_rd_idx >= DEPTH_L;
    pv_d      = req_v_q;
    pix_d     = pix_q;
    if (req_v_q) begin
      pix_d = req_oor_q ? 8'h00 : composer_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_v_q   <= 1'b0;
      req_oor_q <= 1'b0;
      pix_q     <= '0;
      pv_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_v_q   <= req_v_d;
      req_oor_q <= req_oor_d;
      pix_q     <= pix_d;
      pv_q      <= pv_d;
      done_q    <= done_d;
    end
  end

  assign pixel_data  = pix_q;
  assign pixel_valid = pv_q;
  assign line_done   = done_q;
  assign busy        = (state_q != IDLE) | req_v_q;

endmodule

// File: tb/tb_layer_line_reader.sv
// Scoreboard bench for layer_line_reader.
// 800-pixel lines so the >= 768 masking is reached at 1:1 as well.
module tb_layer_line_reader;

  localparam int W = 800;

  typedef struct {
    int data;
    int cyc;
  } exp_t;

  logic       clk = 0;
  logic       rst = 1;
  logic       line_start = 0;
  logic       next_pixel = 0;
  logic [7:0] hscale = 8'd128;
  logic [9:0] rd_idx;
  logic [7:0] rd_data = 0;
  logic [7:0] pixel_data;
  logic       pixel_valid;
  logic       line_done;
  logic       busy;

  logic [7:0] mem [1024];
  exp_t q[$];
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   exp_done = 0;
  int   got_done = 0;
  int   last_v = -10;

  layer_line_reader #(
    .ACTIVE_WIDTH(W),
    .FRAC_BITS(7)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .line_start      (line_start),
    .next_pixel      (next_pixel),
    .hscale          (hscale),
    .composer_rd_idx (rd_idx),
    .composer_rd_data(rd_data),
    .pixel_data      (pixel_data),
    .pixel_valid     (pixel_valid),
    .line_done       (line_done),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_data <= mem[rd_idx];
  end

  function automatic int exp_idx(int k, int h);
`ifdef LAYER_LINE_READER_HSCALE_EN
    return ((k * h) >> 7) & 1023;
`else
    return k & 1023;
`endif
  endfunction

  function automatic int exp_data(int idx);
    return (idx >= 768) ? 0 : (idx & 255);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int act, int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  task automatic push(int k, int h);
    exp_t e;
    e.data = exp_data(exp_idx(k, h));
    e.cyc  = cyc;
    q.push_back(e);
  endtask

  // Runs n fetches of a line; with_fetch puts fetch 0 on the start cycle.
  task automatic line(int h, int n, int gap, bit with_fetch);
    int k0;
    hscale     = 8'(h);
    line_start = 1;
    next_pixel = with_fetch;
    if (with_fetch) push(0, h);
    tick();
    line_start = 0;
    next_pixel = 0;
    k0 = with_fetch ? 1 : 0;
    for (int k = k0; k < n; k++) begin
      next_pixel = 1;
      push(k, h);
      tick();
      next_pixel = 0;
      for (int g = 0; g < gap; g++) begin
        chk("idx_hold", int'(rd_idx), exp_idx(k + 1, h));
        tick();
      end
    end
    if (n == W) exp_done++;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 40; i++) begin
      if (!busy && q.size() == 0) break;
      tick();
    end
    if (i == 40) chk("drain_timeout", 1, 0);
    repeat (3) tick();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pixel_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        e = q.pop_front();
        chk("pixel_data", int'(pixel_data), e.data);
        chk("latency", cyc - e.cyc, 2);
      end
      last_v = cyc;
    end
    if (line_done) begin
      got_done++;
      chk("done_timing", cyc - last_v, 1);
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = (i < 768) ? 8'(i) : 8'hFF;
    end
    repeat (2) tick();
    rst = 0;
    chk("rst_valid", int'(pixel_valid), 0);
    chk("rst_data", int'(pixel_data), 0);
    chk("rst_done", int'(line_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_idx", int'(rd_idx), 0);

    line(128, W, 0, 0);
    drain();
    line(64, W, 0, 0);
    drain();
    line(255, W, 0, 0);
    drain();
    line(128, W, 3, 0);
    drain();

    line(128, 300, 0, 0);
    line(64, W, 0, 1);
    drain();

    line(128, 100, 0, 0);
    rst        = 1;
    next_pixel = 1;
    while (q.size() > 0 && q[$].cyc >= cyc - 1) void'(q.pop_back());
    tick();
    rst = 0;
    chk("mid_rst_valid", int'(pixel_valid), 0);
    chk("mid_rst_data", int'(pixel_data), 0);
    chk("mid_rst_done", int'(line_done), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_idx", int'(rd_idx), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_busy", int'(busy), 0);
    end
    next_pixel = 0;
    repeat (4) tick();

    chk("queue_left", q.size(), 0);
    chk("line_done_count", got_done, exp_done);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
